// File: rtl/ci_divider_mc.sv
// Sequential radix-2 restoring divider for the custom-instruction slot.
// Signed/unsigned, quotient or remainder select, divide-by-zero short path, clk_en stalling.
module ci_divider_mc #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             start,
    input  logic [1:0]       n,
    input  logic [WIDTH-1:0] numerator,
    input  logic [WIDTH-1:0] denominator,
    output logic [WIDTH-1:0] quotient,
    output logic             done,
    output logic             busy,
    output logic             div_zero,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_ZERO = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             sel_rem_q, sel_rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic             done_r_q, done_r_d;
    logic             div_zero_q, div_zero_d;

    logic             signed_op;
    logic             num_neg;
    logic             den_neg;
    logic [WIDTH-1:0] num_mag;
    logic [WIDTH-1:0] den_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // Magnitudes are plain unsigned values, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
    assign signed_op = SIGNED_EN && n[0];
    assign num_neg   = signed_op && numerator[WIDTH-1];
    assign den_neg   = signed_op && denominator[WIDTH-1];
    assign num_mag   = num_neg ? -numerator : numerator;
    assign den_mag   = den_neg ? -denominator : denominator;

    // The dividend register shifts out its MSB into the partial remainder and
    // collects quotient bits at its LSB.
    assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        sel_rem_d  = sel_rem_q;
        quotient_d = quotient_q;
        done_r_d   = 1'b0;
        div_zero_d = div_zero_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_rem_d  = n[1];
                    neg_quo_d  = num_neg ^ den_neg;
                    neg_rem_d  = num_neg;
                    rem_d      = '0;
                    cnt_d      = CW'(WIDTH - 1);
                    dvs_d      = den_mag;
                    div_zero_d = 1'b0;
                    if (denominator == '0) begin
                        dvd_d   = numerator;
                        state_d = S_ZERO;
                    end else begin
                        dvd_d   = num_mag;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                dvd_d = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
                rem_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                if (sel_rem_q) begin
                    quotient_d = neg_rem_q ? -rem_q : rem_q;
                end else begin
                    quotient_d = neg_quo_q ? -dvd_q : dvd_q;
                end
                div_zero_d = 1'b0;
                done_r_d   = 1'b1;
                state_d    = S_IDLE;
            end
            S_ZERO: begin
                quotient_d = sel_rem_q ? dvd_q : '1;
                div_zero_d = 1'b1;
                done_r_d   = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            sel_rem_q  <= 1'b0;
            quotient_q <= '0;
            done_r_q   <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (clk_en) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            sel_rem_q  <= sel_rem_d;
            quotient_q <= quotient_d;
            done_r_q   <= done_r_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign quotient  = quotient_q;
    assign done      = done_r_q & clk_en;
    assign busy      = (state_q != S_IDLE);
    assign div_zero  = div_zero_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ci_divider_mc.sv
// Directed bench for ci_divider_mc (WIDTH=32): arithmetic reference model,
// per-done compare process, latency/busy/stall/reset checks in the driver.
module tb_ci_divider_mc;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic        start;
    logic [1:0]  n;
    logic [31:0] numerator;
    logic [31:0] denominator;
    logic [31:0] quotient;
    logic        done;
    logic        busy;
    logic        div_zero;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic        expz_q[$];

    ci_divider_mc #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst),
        .clk_en      (clk_en),
        .start       (start),
        .n           (n),
        .numerator   (numerator),
        .denominator (denominator),
        .quotient    (quotient),
        .done        (done),
        .busy        (busy),
        .div_zero    (div_zero),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division; SV truncates toward zero and % follows the dividend sign.
    function automatic void model(input logic [31:0] num, input logic [31:0] den,
                                  input logic [1:0] nsel,
                                  output logic [31:0] res, output logic dz);
        longint a, b, q, r;
        dz = (den == 32'd0);
        if (dz) begin
            res = nsel[1] ? num : 32'hFFFF_FFFF;
        end else begin
            if (nsel[0]) begin
                a = longint'($signed(num));
                b = longint'($signed(den));
            end else begin
                a = longint'({32'd0, num});
                b = longint'({32'd0, den});
            end
            q = a / b;
            r = a % b;
            res = nsel[1] ? r[31:0] : q[31:0];
        end
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 with quotient 0x%0h expected no done", quotient);
            end else begin
                check("result", {32'd0, quotient}, {32'd0, exp_q.pop_front()});
                check("div_zero", {63'd0, div_zero}, {63'd0, expz_q.pop_front()});
            end
        end
    end

    task automatic do_op(input string name, input logic [31:0] num, input logic [31:0] den,
                         input logic [1:0] nsel, input logic [31:0] lit, input logic lit_dz,
                         input int exp_lat, input int stall_at, input int stall_len,
                         input int ign_at);
        logic [31:0] m_res;
        logic        m_dz;
        int          e;
        bit          seen;
        model(num, den, nsel, m_res, m_dz);
        check({name, "_model"}, {32'd0, m_res}, {32'd0, lit});
        check({name, "_model_dz"}, {63'd0, m_dz}, {63'd0, lit_dz});
        exp_q.push_back(m_res);
        expz_q.push_back(m_dz);
        @(posedge clk); #1;
        start = 1'b1; numerator = num; denominator = den; n = nsel;
        @(posedge clk); #1;
        start = 1'b0;
        e = 0;
        seen = 0;
        while (!seen && e < 200) begin
            @(negedge clk);
            if (e == 0 && exp_lat > 1) check({name, "_busy_run"}, {63'd0, busy}, 64'd1);
            if (!clk_en) check({name, "_done_stalled"}, {63'd0, done}, 64'd0);
            if (done) begin
                seen = 1;
                check({name, "_latency"}, 64'(e), 64'(exp_lat));
                check({name, "_busy_done"}, {63'd0, busy}, 64'd0);
            end else begin
                @(posedge clk);
                e++;
                #1;
                if (e == stall_at) clk_en = 1'b0;
                if (e == stall_at + stall_len) clk_en = 1'b1;
                if (e == ign_at) begin
                    start = 1'b1; numerator = 32'h0BAD_F00D; denominator = 32'd3; n = 2'b10;
                end
                if (e == ign_at + 1) start = 1'b0;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done in %0d edges expected done at %0d", name, e, exp_lat);
            exp_q.delete();
            expz_q.delete();
            clk_en = 1'b1;
            start = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; start = 1'b0; n = 2'b00;
        numerator = '0; denominator = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_quotient", {32'd0, quotient}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_div_zero", {63'd0, div_zero}, 64'd0);

        do_op("u_q",      32'd100, 32'd7, 2'b00, 32'd14, 1'b0, 33, -1, 0, -1);
        do_op("u_r",      32'd100, 32'd7, 2'b10, 32'd2,  1'b0, 33, -1, 0, -1);
        do_op("s_q_neg",  32'hFFFF_FF9C, 32'd7, 2'b01, 32'hFFFF_FFF2, 1'b0, 33, -1, 0, -1);
        do_op("s_r_neg",  32'hFFFF_FF9C, 32'd7, 2'b11, 32'hFFFF_FFFE, 1'b0, 33, -1, 0, -1);
        do_op("s_r_pos",  32'd100, 32'hFFFF_FFF9, 2'b11, 32'd2, 1'b0, 33, -1, 0, -1);
        do_op("s_q_small", 32'hFFFF_FFF9, 32'hFFFF_FF9C, 2'b01, 32'd0, 1'b0, 33, -1, 0, -1);
        do_op("s_r_small", 32'hFFFF_FFF9, 32'hFFFF_FF9C, 2'b11, 32'hFFFF_FFF9, 1'b0, 33, -1, 0, -1);
        do_op("z_q",      32'd5, 32'd0, 2'b00, 32'hFFFF_FFFF, 1'b1, 1, -1, 0, -1);
        do_op("z_r",      32'd5, 32'd0, 2'b10, 32'd5, 1'b1, 1, -1, 0, -1);
        do_op("z_clear",  32'd1000, 32'd10, 2'b00, 32'd100, 1'b0, 33, -1, 0, -1);
        do_op("ovf_q",    32'h8000_0000, 32'hFFFF_FFFF, 2'b01, 32'h8000_0000, 1'b0, 33, -1, 0, -1);
        do_op("ovf_r",    32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 32'd0, 1'b0, 33, -1, 0, -1);
        do_op("u_big",    32'hFFFF_FFFF, 32'd2, 2'b00, 32'h7FFF_FFFF, 1'b0, 33, -1, 0, -1);
        do_op("u_ovf_pat", 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'd0, 1'b0, 33, -1, 0, -1);
        do_op("stall",    32'd12345, 32'd67, 2'b00, 32'd184, 1'b0, 38, 10, 5, -1);
        do_op("ignore",   32'd7777, 32'd7, 2'b00, 32'd1111, 1'b0, 33, -1, 0, 5);

        // Abort an operation with reset at iteration 10; nothing must complete afterwards.
        @(posedge clk); #1;
        start = 1'b1; numerator = 32'd99999; denominator = 32'd3; n = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_quotient", {32'd0, quotient}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_div_zero", {63'd0, div_zero}, 64'd0);
        repeat (40) @(posedge clk);
        do_op("after_rst", 32'd1000, 32'd10, 2'b00, 32'd100, 1'b0, 33, -1, 0, -1);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ci_divider_mc.md
# ci_divider_mc

Parametrised multi-cycle divider for the Nios II custom-instruction slot that computes the game's velocity and paddle-ratio quotients. It is a sequential radix-2 restoring divider with configurable width, signed or unsigned operation and quotient or remainder selection. It also has divide-by-zero detection, a busy indication, and `clk_en` stalling. The done/start handshake is generated from the block's own state machine, not from a fixed latency counter.

## Interface
- `WIDTH`, default 32: operand and result width in bits; legal range 4 to 64.
- `SIGNED_EN`, default 1: when 0, `n[0]` is ignored and all operations are unsigned; the sign-fix logic is removed.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset; synchronous, active-high (asserted = 1).
- `clk_en` in 1: when 0, all registers hold and `done` is forced low.
- `start` in 1: one-cycle request; sampled only when `clk_en`=1.
- `n` in 2: `n[0]`=1 selects signed; `n[1]`=1 returns the remainder instead of the quotient. Sampled with `start`.
- `numerator` in WIDTH: dividend, sampled with `start`.
- `denominator` in WIDTH: divisor, sampled with `start`.
- `quotient` out WIDTH: registered result, either quotient or remainder per `n[1]`. Holds its value until the next completion.
- `done` out 1: one-cycle completion pulse, equal to `done_r & clk_en`.
- `busy` out 1: high from the accepting edge until the edge that raises `done_r`.
- `div_zero` out 1: registered; valid in the `done` cycle and held until the next accept.

## Operation
- States:
  - IDLE: the only state that accepts `start`.
  - RUN: WIDTH iterations.
  - FIX: sign correction and result register.
  - ZERO: divide-by-zero short path.
- IDLE, on `start & clk_en`:
  - Capture `n`.
  - Take magnitudes: for signed operation with a negative operand, use two's complement, treated as a WIDTH-bit unsigned value. The magnitude of the most-negative value is 2^(WIDTH-1).
  - Record `neg_q = sign(num) ^ sign(den)` and `neg_r = sign(num)`.
  - Clear the partial remainder and set the iteration counter to WIDTH-1.
  - Next state is ZERO if `denominator`==0, else RUN.
- RUN, each enabled cycle:
  - Shift {rem, dividend} left by 1 and trial-subtract the divisor on WIDTH+1 bits.
  - If the difference is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
  - When the counter is 0, go to FIX; otherwise decrement the counter.
- FIX:
  - Negate the quotient if `neg_q` and the remainder if `neg_r` (signed only).
  - Load `quotient` with the quotient or remainder per `n[1]`.
  - Clear `div_zero`, set `done_r`, go to IDLE.
  - Division truncates toward zero; the remainder takes the sign of the numerator.
- ZERO:
  - Load `quotient` with all ones (quotient selected) or the raw `numerator` (remainder selected).
  - Set `div_zero` and `done_r`, go to IDLE.
- Signed overflow, -2^(WIDTH-1) / -1: result is -2^(WIDTH-1) (wraps); remainder is 0; `div_zero` is 0.
- `done_r` is high for exactly one enabled cycle and clears at the next enabled edge.
- `start` while `busy`=1 is ignored; the operation in flight is unaffected.
- `start` in the same cycle as `done` is accepted, since the FSM is already in IDLE.
- `clk_en`=0 freezes the FSM, counter and datapath; `done` is low while frozen. The pending `done_r` is presented when `clk_en` returns.

## Timing
- Reset values: `quotient`=0, `done`=0, `busy`=0, `div_zero`=0, FSM=IDLE, counter=0. Reset overrides `start` and `clk_en`.
- Reset mid-operation aborts the operation: no `done`, and the result is discarded.
- Normal latency: `start` is accepted at edge E0 and `done` is high in the cycle after edge E(WIDTH+1). That is 33 edges for WIDTH=32, plus one edge for every cycle with `clk_en`=0.
- Zero-divisor latency: `done` is high in the cycle after E1.
- Back-to-back throughput is one result per WIDTH+2 cycles.

## Test plan
- Unsigned quotient, WIDTH=32: 100 / 7, `n`=00, gives `quotient`=14 with `done` at E33. Repeat with `n`=10: remainder 2.
- Signed operation: -100 / 7 with `n`=01 gives 0xFFFFFFF2 (-14). With `n`=11 the result is 0xFFFFFFFE (-2). 100 / -7 with `n`=11 gives 2.
- Divide by zero: 5 / 0 with `n`=00 gives 0xFFFFFFFF and `div_zero`=1, with `done` at E1 after accept. With `n`=10 the result is 5. The next valid division clears `div_zero`.
- Signed overflow: 0x80000000 / 0xFFFFFFFF with `n`=01 gives 0x80000000 and `div_zero`=0. With `n`=11 the result is 0.
- Stall and ignored start:
  - Drop `clk_en` for 5 cycles at iteration 10: `done` arrives 5 cycles late with the correct result, and `done` stays low while stalled.
  - Pulse `start` with new operands during `busy`: it is ignored, so exactly one `done` occurs, for the original operands.
- Reset mid-operation: assert `rst_n` at iteration 10. All outputs go to 0, no `done` appears, and a following 1000 / 10 returns 100 with normal latency.
